// File: rtl/ref_clk_train_ctrl.sv
// Reference-clock delay-line training controller.
// The controller sweeps the IOD delay line upward from tap 0 until the sampled
// reference-clock word changes or becomes unstable. It then steps back BACKOFF
// taps from that edge and parks the delay line there.
module ref_clk_train_ctrl #(
    parameter int unsigned TAP_MAX    = 127,
    parameter int unsigned SETTLE_CYC = 8,
    parameter int unsigned SAMPLES    = 16,
    parameter int unsigned BACKOFF    = 8
) (
    input  logic       FAB_CLK,
    input  logic       RESET,
    input  logic       TRAIN_START,
    input  logic [7:0] RX_DATA,
    input  logic       DELAY_LINE_OUT_OF_RANGE,
    output logic       DELAY_LINE_LOAD,
    output logic       DELAY_LINE_MOVE,
    output logic       DELAY_LINE_DIRECTION,
    output logic       EYE_MONITOR_CLEAR_FLAGS,
    output logic       BUSY,
    output logic       TRAIN_DONE,
    output logic       TRAIN_ERR,
    output logic [7:0] TAP_COUNT,
    output logic [7:0] EDGE_TAP
);

    // SETTLE_CYC and SAMPLES must both be at least 1.
    localparam logic [15:0] SettleLast = 16'(SETTLE_CYC - 1);
    localparam logic [15:0] SampleLast = 16'(SAMPLES - 1);
    localparam logic [7:0]  TapMax     = 8'(TAP_MAX);
    // A backoff wider than any tap always saturates to 0, so clamp it to 8 bits.
    localparam int unsigned BackoffSat = (BACKOFF > 255) ? 255 : BACKOFF;
    localparam logic [8:0]  BackoffW   = 9'(BackoffSat);

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StSettle,
        StSample,
        StStep,
        StBack,
        StDone,
        StErr
    } state_e;

    state_e      state_q, state_d;
    logic [7:0]  tap_q, tap_d;
    logic [7:0]  edge_q, edge_d;
    logic [7:0]  ref_q, ref_d;
    logic [7:0]  first_q, first_d;
    logic        unst_q, unst_d;
    logic [15:0] cnt_q, cnt_d;
    logic        from_back_q, from_back_d;
    logic        load_q, load_d;
    logic        move_q, move_d;
    logic        dir_q, dir_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        err_q, err_d;

    logic [8:0]  back_diff;
    logic [7:0]  back_target;
    logic [7:0]  samp_word;
    logic        samp_unst;

    // Next-state, counter and registered-output computation.
    always_comb begin
        state_d     = state_q;
        tap_d       = tap_q;
        edge_d      = edge_q;
        ref_d       = ref_q;
        first_d     = first_q;
        unst_d      = unst_q;
        cnt_d       = cnt_q;
        from_back_d = from_back_q;
        load_d      = 1'b0;
        move_d      = 1'b0;
        dir_d       = dir_q;
        done_d      = done_q;
        err_d       = err_q;

        // Back-off target saturates at tap 0 instead of wrapping.
        back_diff   = {1'b0, edge_q} - BackoffW;
        back_target = back_diff[8] ? 8'd0 : back_diff[7:0];

        // Word and stability of the current tap including this cycle's sample.
        samp_word = (cnt_q == 16'd0) ? RX_DATA : first_q;
        samp_unst = (cnt_q == 16'd0) ? 1'b0 : (unst_q | (RX_DATA != first_q));

        unique case (state_q)
            StIdle, StDone, StErr: begin
                if (TRAIN_START) begin
                    state_d = StLoad;
                    done_d  = 1'b0;
                    err_d   = 1'b0;
                    edge_d  = 8'd0;
                    tap_d   = 8'd0;
                    ref_d   = 8'd0;
                    load_d  = 1'b1;
                end
            end
            StLoad: begin
                state_d     = StSettle;
                cnt_d       = 16'd0;
                from_back_d = 1'b0;
            end
            StSettle: begin
                if (cnt_q == SettleLast) begin
                    cnt_d   = 16'd0;
                    state_d = from_back_q ? StBack : StSample;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            StSample: begin
                first_d = samp_word;
                unst_d  = samp_unst;
                cnt_d   = cnt_q + 16'd1;
                if (cnt_q == SampleLast) begin
                    cnt_d = 16'd0;
                    if (tap_q == 8'd0) begin
                        if (samp_unst) begin
                            state_d = StErr;
                            err_d   = 1'b1;
                        end else begin
                            ref_d   = samp_word;
                            state_d = StStep;
                        end
                    end else if (samp_unst || (samp_word != ref_q)) begin
                        edge_d  = tap_q;
                        state_d = StBack;
                    end else begin
                        state_d = StStep;
                    end
                end
            end
            StStep: begin
                if ((tap_q == TapMax) || DELAY_LINE_OUT_OF_RANGE) begin
                    state_d = StErr;
                    err_d   = 1'b1;
                end else begin
                    move_d      = 1'b1;
                    dir_d       = 1'b1;
                    tap_d       = tap_q + 8'd1;
                    cnt_d       = 16'd0;
                    from_back_d = 1'b0;
                    state_d     = StSettle;
                end
            end
            StBack: begin
                if (tap_q > back_target) begin
                    move_d      = 1'b1;
                    dir_d       = 1'b0;
                    tap_d       = tap_q - 8'd1;
                    cnt_d       = 16'd0;
                    from_back_d = 1'b1;
                    state_d     = StSettle;
                end else begin
                    state_d = StDone;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        busy_d = !((state_d == StIdle) || (state_d == StDone) || (state_d == StErr));
    end

    // State and registered outputs; reset wins over everything including TRAIN_START.
    always_ff @(posedge FAB_CLK) begin
        if (RESET) begin
            state_q     <= StIdle;
            tap_q       <= 8'd0;
            edge_q      <= 8'd0;
            ref_q       <= 8'd0;
            first_q     <= 8'd0;
            unst_q      <= 1'b0;
            cnt_q       <= 16'd0;
            from_back_q <= 1'b0;
            load_q      <= 1'b0;
            move_q      <= 1'b0;
            dir_q       <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            tap_q       <= tap_d;
            edge_q      <= edge_d;
            ref_q       <= ref_d;
            first_q     <= first_d;
            unst_q      <= unst_d;
            cnt_q       <= cnt_d;
            from_back_q <= from_back_d;
            load_q      <= load_d;
            move_q      <= move_d;
            dir_q       <= dir_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    assign DELAY_LINE_LOAD         = load_q;
    assign EYE_MONITOR_CLEAR_FLAGS = load_q;
    assign DELAY_LINE_MOVE         = move_q;
    assign DELAY_LINE_DIRECTION    = dir_q;
    assign BUSY                    = busy_q;
    assign TRAIN_DONE              = done_q;
    assign TRAIN_ERR               = err_q;
    assign TAP_COUNT               = tap_q;
    assign EDGE_TAP                = edge_q;

endmodule

// File: doc/ref_clk_train_ctrl.md
REF_CLK_TRAIN_CTRL -- requirements
Module: ref_clk_train_ctrl

Interface
REQ-001 Parameter TAP_MAX, default 127: highest legal delay-line tap index.
REQ-002 Parameter SETTLE_CYC, default 8: wait cycles after any delay-line load or move before sampling.
REQ-003 Parameter SAMPLES, default 16: RX_DATA words examined per tap.
REQ-004 Parameter BACKOFF, default 8: taps to step back from the detected edge.
REQ-005 FAB_CLK  in  1  sole clock; all logic on rising edge.
REQ-006 RESET  in  1  synchronous, active-high reset.
REQ-007 TRAIN_START  in  1  one-cycle request to begin training.
REQ-008 RX_DATA  in  8  deserialized reference-clock word from the IOD.
REQ-009 DELAY_LINE_OUT_OF_RANGE  in  1  IOD delay-line limit flag.
REQ-010 DELAY_LINE_LOAD  out  1  one-cycle pulse; reloads the IOD delay line to tap 0.
REQ-011 DELAY_LINE_MOVE  out  1  one-cycle pulse; moves the delay line one tap.
REQ-012 DELAY_LINE_DIRECTION  out  1  1 = increment, 0 = decrement; valid whenever MOVE is high.
REQ-013 EYE_MONITOR_CLEAR_FLAGS  out  1  one-cycle pulse, coincident with LOAD.
REQ-014 BUSY  out  1  high in any state other than IDLE, DONE, or ERR.
REQ-015 TRAIN_DONE  out  1  training succeeded.
REQ-016 TRAIN_ERR  out  1  training failed.
REQ-017 TAP_COUNT  out  8  current delay-line tap as tracked by this block.
REQ-018 EDGE_TAP  out  8  tap at which the clock edge was detected.

Function
REQ-019 The FSM SHALL have the states IDLE, LOAD, SETTLE, SAMPLE, STEP, BACK, DONE, and ERR.
REQ-020 In IDLE, DONE, or ERR, TRAIN_START SHALL cause a transition to LOAD on the next cycle and SHALL clear TRAIN_DONE, TRAIN_ERR, and EDGE_TAP.
REQ-021 In any other state, TRAIN_START SHALL be ignored.
REQ-022 LOAD SHALL last one cycle and SHALL assert DELAY_LINE_LOAD and EYE_MONITOR_CLEAR_FLAGS, set TAP_COUNT=0, clear the reference pattern, and go to SETTLE.
REQ-023 SETTLE SHALL count exactly SETTLE_CYC cycles and SHALL then go to SAMPLE (when entered from BACK, it SHALL return to BACK).
REQ-024 SAMPLE SHALL register RX_DATA for SAMPLES consecutive cycles.
REQ-025 A tap is "stable" when all SAMPLES words equal the first word of that tap.
REQ-026 At tap 0: if stable, the first word SHALL be stored as the reference pattern; if unstable, the FSM SHALL go to ERR.
REQ-027 At tap k>0, an edge is found when the tap is unstable or the stable word differs from the reference pattern.
REQ-028 When an edge is found, EDGE_TAP SHALL be set to k and the FSM SHALL go to BACK; otherwise the FSM SHALL go to STEP.
REQ-029 STEP SHALL go to ERR when TAP_COUNT==TAP_MAX or DELAY_LINE_OUT_OF_RANGE==1 (sampled in STEP).
REQ-030 Otherwise, STEP SHALL pulse DELAY_LINE_MOVE with DIRECTION=1 for one cycle, increment TAP_COUNT, and go to SETTLE.
REQ-031 BACK SHALL target the tap max(EDGE_TAP-BACKOFF, 0), saturating at 0 with no wrap.
REQ-032 While TAP_COUNT > target, BACK SHALL issue one MOVE pulse with DIRECTION=0, decrement TAP_COUNT, and pass through SETTLE.
REQ-033 When TAP_COUNT == target, BACK SHALL go to DONE.
REQ-034 Consecutive MOVE pulses SHALL be separated by at least SETTLE_CYC+1 cycles.
REQ-035 DONE SHALL hold TRAIN_DONE=1; ERR SHALL hold TRAIN_ERR=1; TRAIN_DONE and TRAIN_ERR SHALL never both be high.
REQ-036 DIRECTION SHALL hold its last value between MOVE pulses.
REQ-037 TAP_COUNT arithmetic SHALL be 8-bit unsigned and never wrap; TAP_MAX SHALL be ≤255.

Reset
REQ-038 RESET SHALL force the state to IDLE and drive all outputs to 0.
REQ-039 RESET SHALL clear all counters and the reference pattern.
REQ-040 RESET SHALL take priority over TRAIN_START in the same cycle.
REQ-041 RESET asserted mid-training SHALL abort training without emitting any further MOVE or LOAD pulse.

Verification
REQ-042 Scenario: defaults; RX_DATA=0x55 for taps 0-39, 0xAA from tap 40 -> EDGE_TAP=40; 40 increment pulses then 8 decrement pulses; TAP_COUNT=32; TRAIN_DONE=1.
REQ-043 Scenario: edge at tap 5 with BACKOFF=8 -> 5 decrement pulses; TAP_COUNT=0; TRAIN_DONE=1.
REQ-044 Scenario: RX_DATA constant 0x55 at every tap -> 127 increment pulses; TRAIN_ERR=1; TAP_COUNT=127.
REQ-045 Scenario: DELAY_LINE_OUT_OF_RANGE=1 in STEP at tap 20 -> TRAIN_ERR=1; no 21st MOVE pulse.
REQ-046 Scenario: RX_DATA toggling 0x55/0x54 at tap 0 -> TRAIN_ERR=1; no MOVE pulse.
REQ-047 Scenario: RESET at tap 10, then TRAIN_START -> outputs 0 during reset; a fresh LOAD follows; the sequence repeats from tap 0.
